exe_pipe_ctrl: RTL

Pipeline sequencing controller for the execute stage. It owns the architectural NZCV status register that feeds the execute stage's `Status` input. It detects register-dependency hazards between decode and the execute/memory stages, and flushes the front end on taken branches. It also runs a counter FSM that holds the pipeline while a multi-cycle multiply occupies the ALU.

---
 rtl/exe_pipe_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/exe_pipe_ctrl.sv
// exe_pipe_ctrl -- execute-stage sequencing controller.
//
// Owns the architectural NZCV status register, holds the pipeline while a
// multi-cycle multiply occupies the ALU, flushes the front end on taken
// branches, detects decode register hazards and generates operand-forwarding
// selects for the execute stage.
//
// Optional feature macro: EXE_FORWARDING_EN
//   defined   : Fwd_Sel1/2 active, decode stalls only on load-use.
//   undefined : Fwd_Sel1/2 tied to 00, decode stalls on any in-flight writer
//               in execute or memory.
//
// Parameters
//   MUL_LAT  total execute-stage cycles of a multiply (>= 2)
//   MUL_CMD  EXE_CMD encoding that selects the multiply
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   ID_*                            decode-stage sources and enables
//   EXE_*                           execute-stage control, command, regs
//   ALU_Status                      {N,Z,C,V} from the ALU this cycle
//   MEM_WB_EN, MEM_Dest             memory-stage writer
//   WB_WB_EN, WB_Dest               write-back-stage writer
//   Status                          registered {N,Z,C,V}
//   Hazard_Stall, Hold, Flush       pipeline sequencing controls
//   Mul_Start, Mul_Done             multiply entry / final-cycle pulses
//   Fwd_Sel1, Fwd_Sel2              00 regfile, 01 memory result, 10 WB result
module exe_pipe_ctrl #(
   parameter int         MUL_LAT = 4,
   parameter logic [3:0] MUL_CMD = 4'b1111
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ID_Valid,
   input  logic [3:0] ID_Src1,
   input  logic [3:0] ID_Src2,
   input  logic       ID_Src1_EN,
   input  logic       ID_Src2_EN,
   input  logic       EXE_Valid,
   input  logic       EXE_WB_EN,
   input  logic       EXE_MEM_R_EN,
   input  logic       EXE_S,
   input  logic       EXE_B,
   input  logic [3:0] EXE_CMD,
   input  logic [3:0] EXE_Dest,
   input  logic [3:0] EXE_Src1,
   input  logic [3:0] EXE_Src2,
   input  logic       EXE_Src1_EN,
   input  logic       EXE_Src2_EN,
   input  logic [3:0] ALU_Status,
   input  logic       MEM_WB_EN,
   input  logic [3:0] MEM_Dest,
   input  logic       WB_WB_EN,
   input  logic [3:0] WB_Dest,
   output logic [3:0] Status,
   output logic       Hazard_Stall,
   output logic       Hold,
   output logic       Flush,
   output logic       Mul_Start,
   output logic       Mul_Done,
   output logic [1:0] Fwd_Sel1,
   output logic [1:0] Fwd_Sel2
);

   localparam int              CNT_W    = $clog2(MUL_LAT);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 2);
   localparam logic [0:0]      ST_IDLE  = 1'b0;
   localparam logic [0:0]      ST_BUSY  = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       status_q, status_d;

   logic hold_raw, start_raw, done_raw;
   logic flush_raw, hazard;
   logic src1_live, src2_live;
   logic [1:0] fwd1_raw, fwd2_raw;

   // Multiply sequencer: the entry cycle plus MUL_LAT-2 counted cycles hold,
   // the final cycle releases. A multiply queued behind is picked up from IDLE.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hold_raw  = 1'b0;
      start_raw = 1'b0;
      done_raw  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (EXE_Valid && (EXE_CMD == MUL_CMD)) begin
               start_raw = 1'b1;
               hold_raw  = 1'b1;
               cnt_d     = CNT_LOAD;
               state_d   = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (cnt_q != '0) begin
               hold_raw = 1'b1;
               cnt_d    = cnt_q - CNT_W'(1);
            end else begin
               done_raw = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Flags commit only when the instruction is not being held, so a
   // multiply updates NZCV on its final cycle.
   always_comb begin
      status_d = status_q;
      if (EXE_Valid && EXE_S && !hold_raw) begin
         status_d = ALU_Status;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         status_q <= 4'b0000;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         status_q <= status_d;
      end
   end

   assign src1_live = ID_Valid & ID_Src1_EN;
   assign src2_live = ID_Valid & ID_Src2_EN;
   assign flush_raw = EXE_Valid & EXE_B & ~hold_raw;

`ifdef EXE_FORWARDING_EN
   function automatic logic [1:0] fwd_sel(input logic en, input logic [3:0] src,
                                          input logic mem_we, input logic [3:0] mem_d,
                                          input logic wb_we, input logic [3:0] wb_d);
      logic [1:0] sel;
      sel = 2'b00;
      // Memory stage holds the younger value, so it wins over write-back.
      if (en && mem_we && (mem_d == src)) begin
         sel = 2'b01;
      end else if (en && wb_we && (wb_d == src)) begin
         sel = 2'b10;
      end
      return sel;
   endfunction

   logic unused_fwd_cfg;
   assign unused_fwd_cfg = EXE_WB_EN;

   // Only a load in execute cannot be forwarded in time.
   assign hazard = EXE_Valid & EXE_MEM_R_EN &
                   ((src1_live & (ID_Src1 == EXE_Dest)) |
                    (src2_live & (ID_Src2 == EXE_Dest)));
   assign fwd1_raw = fwd_sel(EXE_Src1_EN, EXE_Src1, MEM_WB_EN, MEM_Dest, WB_WB_EN, WB_Dest);
   assign fwd2_raw = fwd_sel(EXE_Src2_EN, EXE_Src2, MEM_WB_EN, MEM_Dest, WB_WB_EN, WB_Dest);
`else
   logic unused_nofwd_cfg;
   assign unused_nofwd_cfg = ^{EXE_MEM_R_EN, EXE_Src1, EXE_Src2, EXE_Src1_EN,
                               EXE_Src2_EN, WB_WB_EN, WB_Dest};

   // Without forwarding any pending writer in execute or memory must drain.
   assign hazard = (EXE_Valid & EXE_WB_EN &
                    ((src1_live & (ID_Src1 == EXE_Dest)) |
                     (src2_live & (ID_Src2 == EXE_Dest)))) |
                   (MEM_WB_EN &
                    ((src1_live & (ID_Src1 == MEM_Dest)) |
                     (src2_live & (ID_Src2 == MEM_Dest))));
   assign fwd1_raw = 2'b00;
   assign fwd2_raw = 2'b00;
`endif

   // Hold already freezes the front end and a flush discards decode, so
   // both take precedence over the hazard stall.
   assign Status       = status_q;
   assign Hold         = hold_raw & rst_n;
   assign Mul_Start    = start_raw & rst_n;
   assign Mul_Done     = done_raw & rst_n;
   assign Flush        = flush_raw & rst_n;
   assign Hazard_Stall = hazard & ~hold_raw & ~flush_raw & rst_n;
   assign Fwd_Sel1     = rst_n ? fwd1_raw : 2'b00;
   assign Fwd_Sel2     = rst_n ? fwd2_raw : 2'b00;

endmodule
